// File: rtl/count_lockstep_ctrl.sv
// count_lockstep_ctrl: sequences resets for two lockstep counters, checks they match over a window, retries on mismatch
module count_lockstep_ctrl #(
   parameter int WIDTH      = 32,
   parameter int WINDOW     = 16,
   parameter int RST_CYCLES = 2,
   parameter int MAX_RETRY  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             inject,
   input  logic [WIDTH-1:0] cnt1,
   input  logic [WIDTH-1:0] cnt2,
   output logic             rstn1,
   output logic             rstn2,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic [3:0]       retry_cnt,
   output logic [7:0]       mismatch_cnt,
   output logic [WIDTH-1:0] mm_cnt1,
   output logic [WIDTH-1:0] mm_cnt2
);

   localparam int WW = $clog2(WINDOW);
   localparam int RW = $clog2(RST_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, RESET, COMPARE, RESYNC, PASS, FAIL} state_t;

   state_t        state;
   logic [WW-1:0] win;
   logic [RW-1:0] rc;

   // Control FSM; every output is registered and takes the value of the state being entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         win          <= '0;
         rc           <= '0;
         rstn1        <= 1'b0;
         rstn2        <= 1'b0;
         busy         <= 1'b0;
         pass         <= 1'b0;
         fail         <= 1'b0;
         retry_cnt    <= '0;
         mismatch_cnt <= '0;
         mm_cnt1      <= '0;
         mm_cnt2      <= '0;
      end else begin
         rstn1 <= 1'b1;
         rstn2 <= 1'b1;
         case (state)
            IDLE, PASS, FAIL: begin
               if (start) begin
                  state        <= RESET;
                  rc           <= '0;
                  rstn1        <= 1'b0;
                  rstn2        <= 1'b0;
                  busy         <= 1'b1;
                  pass         <= 1'b0;
                  fail         <= 1'b0;
                  retry_cnt    <= '0;
                  mismatch_cnt <= '0;
                  mm_cnt1      <= '0;
                  mm_cnt2      <= '0;
               end
            end
            RESET: begin
               if (rc == RW'(RST_CYCLES - 1)) begin
                  state <= COMPARE;
                  win   <= '0;
               end else begin
                  rc    <= rc + 1'b1;
                  rstn1 <= 1'b0;
                  rstn2 <= 1'b0;
               end
            end
            COMPARE: begin
               rstn1 <= !inject;
               if (cnt1 != cnt2) begin
                  mismatch_cnt <= (mismatch_cnt == 8'hff) ? mismatch_cnt : mismatch_cnt + 8'd1;
                  mm_cnt1      <= cnt1;
                  mm_cnt2      <= cnt2;
                  if (retry_cnt < 4'(MAX_RETRY)) begin
                     state <= RESYNC;
                  end else begin
                     state <= FAIL;
                     busy  <= 1'b0;
                     fail  <= 1'b1;
                  end
               end else if (win == WW'(WINDOW - 1)) begin
                  state <= PASS;
                  busy  <= 1'b0;
                  pass  <= 1'b1;
               end else begin
                  win <= win + 1'b1;
               end
            end
            RESYNC: begin
               state     <= RESET;
               rc        <= '0;
               retry_cnt <= retry_cnt + 4'd1;
               rstn1     <= 1'b0;
               rstn2     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_count_lockstep_ctrl.sv
// tb_count_lockstep_ctrl: directed scenarios for the lockstep counter check controller
module tb_count_lockstep_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        inject = 1'b0;
   logic        skew = 1'b0;
   logic [31:0] c1 = '0;
   logic [31:0] c2 = '0;
   logic [31:0] cnt1, cnt2;
   logic        rstn1, rstn2, busy, pass, fail;
   logic [3:0]  retry_cnt;
   logic [7:0]  mismatch_cnt;
   logic [31:0] mm_cnt1, mm_cnt2;
   int          checks = 0;
   int          errors = 0;

   count_lockstep_ctrl #(.WIDTH(32), .WINDOW(16), .RST_CYCLES(2), .MAX_RETRY(2)) dut (
      .clk(clk), .rst(rst), .start(start), .inject(inject), .cnt1(cnt1), .cnt2(cnt2),
      .rstn1(rstn1), .rstn2(rstn2), .busy(busy), .pass(pass), .fail(fail),
      .retry_cnt(retry_cnt), .mismatch_cnt(mismatch_cnt), .mm_cnt1(mm_cnt1), .mm_cnt2(mm_cnt2)
   );

   always #5 clk = ~clk;

   // Two free-running counters with synchronous active-low resets
   always @(posedge clk) begin
      c1 <= rstn1 ? c1 + 32'd1 : 32'd0;
      c2 <= rstn2 ? c2 + 32'd1 : 32'd0;
   end

   assign cnt1 = c1;
   assign cnt2 = skew ? c1 + 32'd1 : c2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++; if (rstn1 !== 1'b0 || rstn2 !== 1'b0) begin errors++; $display("FAIL reset_rstn: rstn1=%b rstn2=%b expected 0 0", rstn1, rstn2); end
      checks++; if ({busy, pass, fail} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/pass/fail=%b expected 000", {busy, pass, fail}); end
      checks++; if (retry_cnt !== 4'd0 || mismatch_cnt !== 8'd0 || mm_cnt1 !== 32'd0 || mm_cnt2 !== 32'd0) begin errors++; $display("FAIL reset_counts: retry=%0d mm=%0d mm1=%0d mm2=%0d expected all 0", retry_cnt, mismatch_cnt, mm_cnt1, mm_cnt2); end
      rst = 1'b0;
      tick();
      checks++; if (rstn1 !== 1'b1 || rstn2 !== 1'b1) begin errors++; $display("FAIL reset_release: rstn1=%b rstn2=%b expected 1 1", rstn1, rstn2); end
   endtask

   task automatic test_inject_idle();
      inject = 1'b1;
      tick();
      inject = 1'b0;
      checks++; if (rstn1 !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL inject_idle: rstn1=%b busy=%b expected 1 0", rstn1, busy); end
   endtask

   task automatic test_clean();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (rstn1 !== 1'b0 || rstn2 !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL clean_edge0: rstn1=%b rstn2=%b busy=%b expected 0 0 1", rstn1, rstn2, busy); end
      tick();
      checks++; if (rstn1 !== 1'b0 || rstn2 !== 1'b0) begin errors++; $display("FAIL clean_edge1: rstn1=%b rstn2=%b expected 0 0", rstn1, rstn2); end
      tick();
      checks++; if (rstn1 !== 1'b1 || rstn2 !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL clean_edge2: rstn1=%b rstn2=%b busy=%b expected 1 1 1", rstn1, rstn2, busy); end
      for (int i = 3; i <= 17; i++) tick();
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL clean_edge17: pass=%b expected 0", pass); end
      tick();
      checks++; if (pass !== 1'b1 || busy !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL clean_edge18: pass=%b busy=%b fail=%b expected 1 0 0", pass, busy, fail); end
      checks++; if (retry_cnt !== 4'd0 || mismatch_cnt !== 8'd0) begin errors++; $display("FAIL clean_counts: retry=%0d mm=%0d expected 0 0", retry_cnt, mismatch_cnt); end
   endtask

   task automatic test_inject_pass();
      inject = 1'b1;
      tick();
      inject = 1'b0;
      checks++; if (rstn1 !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL inject_pass_state: rstn1=%b pass=%b expected 1 1", rstn1, pass); end
   endtask

   task automatic test_inject_compare();
      int n;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 5; i++) tick();
      inject = 1'b1;
      tick();
      inject = 1'b0;
      checks++; if (rstn1 !== 1'b0 || rstn2 !== 1'b1) begin errors++; $display("FAIL inject_rstn: rstn1=%b rstn2=%b expected 0 1", rstn1, rstn2); end
      tick();
      checks++; if (rstn1 !== 1'b1) begin errors++; $display("FAIL inject_one_cycle: rstn1=%b expected 1", rstn1); end
      n = 0;
      while (!pass && !fail && n < 80) begin tick(); n++; end
      checks++; if (pass !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL inject_result: pass=%b fail=%b expected 1 0", pass, fail); end
      checks++; if (retry_cnt !== 4'd1 || mismatch_cnt !== 8'd1) begin errors++; $display("FAIL inject_counts: retry=%0d mm=%0d expected 1 1", retry_cnt, mismatch_cnt); end
      checks++; if (mm_cnt1 === mm_cnt2 || mm_cnt1 > 32'd1) begin errors++; $display("FAIL inject_capture: mm1=%0d mm2=%0d expected mm1<=1 and mm1!=mm2", mm_cnt1, mm_cnt2); end
   endtask

   task automatic test_fail();
      int n;
      skew = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!pass && !fail && n < 80) begin tick(); n++; end
      checks++; if (fail !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fail_flags: fail=%b pass=%b busy=%b expected 1 0 0", fail, pass, busy); end
      checks++; if (retry_cnt !== 4'd2 || mismatch_cnt !== 8'd3) begin errors++; $display("FAIL fail_counts: retry=%0d mm=%0d expected 2 3", retry_cnt, mismatch_cnt); end
      checks++; if (mm_cnt2 !== mm_cnt1 + 32'd1) begin errors++; $display("FAIL fail_capture: mm1=%0d mm2=%0d expected mm2=mm1+1", mm_cnt1, mm_cnt2); end
      inject = 1'b1;
      tick();
      inject = 1'b0;
      checks++; if (rstn1 !== 1'b1 || fail !== 1'b1 || retry_cnt !== 4'd2) begin errors++; $display("FAIL inject_fail_state: rstn1=%b fail=%b retry=%0d expected 1 1 2", rstn1, fail, retry_cnt); end
      skew = 1'b0;
   endtask

   task automatic test_restart_busy_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (fail !== 1'b0 || busy !== 1'b1 || retry_cnt !== 4'd0 || mismatch_cnt !== 8'd0) begin errors++; $display("FAIL restart_clear: fail=%b busy=%b retry=%0d mm=%0d expected 0 1 0 0", fail, busy, retry_cnt, mismatch_cnt); end
      for (int i = 1; i <= 4; i++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (rstn1 !== 1'b1 || rstn2 !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL busy_start: rstn1=%b rstn2=%b busy=%b expected 1 1 1", rstn1, rstn2, busy); end
      for (int i = 6; i <= 17; i++) tick();
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL restart_edge17: pass=%b expected 0", pass); end
      tick();
      checks++; if (pass !== 1'b1 || retry_cnt !== 4'd0 || mismatch_cnt !== 8'd0) begin errors++; $display("FAIL restart_edge18: pass=%b retry=%0d mm=%0d expected 1 0 0", pass, retry_cnt, mismatch_cnt); end
   endtask

   task automatic test_async_rst();
      skew = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 6; i++) tick();
      checks++; if (mismatch_cnt !== 8'd1 || retry_cnt !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL pre_rst_counts: mm=%0d retry=%0d busy=%b expected 1 1 1", mismatch_cnt, retry_cnt, busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || rstn1 !== 1'b0 || rstn2 !== 1'b0) begin errors++; $display("FAIL async_rst_out: busy=%b rstn1=%b rstn2=%b expected 0 0 0", busy, rstn1, rstn2); end
      checks++; if (retry_cnt !== 4'd0 || mismatch_cnt !== 8'd0 || mm_cnt1 !== 32'd0 || mm_cnt2 !== 32'd0) begin errors++; $display("FAIL async_rst_counts: retry=%0d mm=%0d mm1=%0d mm2=%0d expected all 0", retry_cnt, mismatch_cnt, mm_cnt1, mm_cnt2); end
      skew = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 25; i++) tick();
      checks++; if ({busy, pass, fail} !== 3'b000 || rstn1 !== 1'b1) begin errors++; $display("FAIL post_rst_idle: busy/pass/fail=%b rstn1=%b expected 000 1", {busy, pass, fail}, rstn1); end
   endtask

   initial begin
      #1;
      test_reset();
      test_inject_idle();
      test_clean();
      test_inject_pass();
      test_inject_compare();
      test_fail();
      test_restart_busy_start();
      test_async_rst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_lockstep_ctrl.md
# count_lockstep_ctrl

Sequencing controller for a pair of free-running counters that run in lockstep and have their outputs compared. It drives each counter's active-low reset and checks that the counts match for a fixed window. On a mismatch it re-synchronises both counters and retries, up to a limit, then reports pass or fail. It sits above the dual-counter top and replaces testbench-driven reset sequencing with a self-checking hardware sequence.

## Interface
Parameters:
- WIDTH, 32, counter width.
- WINDOW, 16, number of consecutive matching compare cycles required for pass; must be ≥ 2.
- RST_CYCLES, 2, number of cycles both counter resets are held low per sync attempt; must be ≥ 1.
- MAX_RETRY, 3, number of resyncs allowed before fail; must be ≤ 15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a check; honoured only in IDLE, PASS or FAIL.
- inject  in  1  fault injection; honoured only in COMPARE.
- cnt1  in  WIDTH  count from counter 1.
- cnt2  in  WIDTH  count from counter 2.
- rstn1  out  1  registered active-low reset to counter 1.
- rstn2  out  1  registered active-low reset to counter 2.
- busy  out  1  high in RESET, COMPARE and RESYNC.
- pass  out  1  high in PASS.
- fail  out  1  high in FAIL.
- retry_cnt  out  4  number of resyncs in the current check.
- mismatch_cnt  out  8  mismatching compare cycles in the current check; saturates at 255.
- mm_cnt1  out  WIDTH  cnt1 value captured at the most recent mismatch.
- mm_cnt2  out  WIDTH  cnt2 value captured at the most recent mismatch.

## Operation
States:
- IDLE: rstn1 = rstn2 = 1; the counters free-run.
  - start -> RESET.
  - Clears retry_cnt, mismatch_cnt, mm_cnt1 and mm_cnt2.
- RESET: rstn1 = rstn2 = 0 for exactly RST_CYCLES cycles, then -> COMPARE with the window counter at 0.
- COMPARE: rstn1 = rstn2 = 1. Each cycle, compare cnt1 against cnt2 combinationally.
  - Match: increment the window counter. If the window counter equals WINDOW−1 -> PASS.
  - Mismatch: increment mismatch_cnt (saturating) and capture mm_cnt1/mm_cnt2. Then go to RESYNC if retry_cnt < MAX_RETRY, else to FAIL.
  - A mismatch always takes priority over window completion in the same cycle.
- RESYNC: one cycle; retry_cnt += 1; -> RESET.
- PASS / FAIL: rstn1 = rstn2 = 1; the flag holds until start is seen.
  - start -> RESET and clears retry_cnt, mismatch_cnt, mm_cnt1 and mm_cnt2, exactly as in IDLE.

Fault injection:
- inject sampled high in COMPARE drives rstn1 = 0 for exactly one cycle.
- Injection does not itself change state; the resulting count divergence is what gets detected.
- inject held high for N cycles gives N consecutive low cycles on rstn1.

Ignored inputs:
- start is ignored in RESET, COMPARE and RESYNC.
- inject is ignored in every state other than COMPARE.

## Timing
Reset values (while rst is high):
- state = IDLE.
- rstn1 = rstn2 = 0, which holds the counters reset.
- busy = pass = fail = 0.
- retry_cnt = 0, mismatch_cnt = 0, mm_cnt1 = mm_cnt2 = 0.
- On the first edge after rst deasserts, rstn1 and rstn2 go to 1.

Cycle-level behaviour:
- All outputs are registered and change on the edge that enters the state.
- start sampled at edge k: rstn1 = rstn2 = 0 and busy = 1 from edge k.
- COMPARE is entered at edge k+RST_CYCLES.
- Clean run: pass = 1 from edge k+RST_CYCLES+WINDOW.
- Each resync adds 1 + RST_CYCLES + (cycles spent in COMPARE) to the run.
- inject sampled at edge j: rstn1 = 0 during cycle j..j+1. The counters diverge at the following edge, and the mismatch is sampled at edge j+2 at the latest.
- rst asserted mid-operation returns the block to reset values immediately, with no wait for the next edge.

## Test plan
All scenarios use WINDOW=16, RST_CYCLES=2, MAX_RETRY=2.
- Clean check: start at edge 0.
  - Expect rstn1/rstn2 low for edges 0–1, pass = 1 at edge 18.
  - Expect retry_cnt = 0, mismatch_cnt = 0.
- Single inject at the 5th COMPARE cycle.
  - Expect one RESYNC, then a clean window: pass = 1, retry_cnt = 1, mismatch_cnt = 1.
  - Expect mm_cnt1 ≠ mm_cnt2, with mm_cnt1 = 0 or 1.
- cnt2 forced to cnt1+1 throughout.
  - Expect 3 mismatches and 2 resyncs, then fail = 1.
  - Expect retry_cnt = 2, mismatch_cnt = 3, pass = 0.
- start pulsed while busy, and inject pulsed in IDLE/PASS.
  - Expect no change to state, counters or rstn outputs.
- Restart: start while in FAIL.
  - Expect fail to clear, retry_cnt = 0, mismatch_cnt = 0.
  - Expect a clean check, then pass 18 cycles later.
- rst asserted mid-COMPARE.
  - Expect busy = 0, rstn1 = rstn2 = 0 and all counts = 0 immediately.
  - Expect IDLE after release, with no pass or fail raised.
